// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm scheduler and its slot bank.
// State encodings are plain constants so legacy tools see ordinary vectors.
package alarm_pkg;

    localparam int TIME_W = 6;

    localparam logic [3:0] CHIME_SRC = 4'd15;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t RING   = 2'd1;
    localparam state_t SNOOZE = 2'd2;

    typedef struct packed {
        logic [TIME_W-1:0] hour;
        logic [TIME_W-1:0] minute;
        logic [TIME_W-1:0] second;
    } hms_t;

endpackage

// File: rtl/alarm_slot_bank.sv
// Programmable alarm slots: stored time + enable per slot and a per-slot
// match against the current time. Priority selection lives in the parent.
module alarm_slot_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4
) (
    input  logic                  CLK_50,
    input  logic                  RST_N,
    input  logic                  set_valid,
    input  logic [2:0]            set_idx,
    input  hms_t                  set_time,
    input  logic                  set_enable,
    input  hms_t                  now,
    output logic [NUM_ALARMS-1:0] slot_match,
    output logic [NUM_ALARMS-1:0] slot_enabled
);

    hms_t                  time_q [NUM_ALARMS];
    hms_t                  time_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] enable_q;
    logic [NUM_ALARMS-1:0] enable_d;

    // An index outside the bank never equals any loop value, so it is dropped.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        time_d   = time_q;
        enable_d = enable_q;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (set_valid && (set_idx == 3'(i))) begin
                time_d[i]   = set_time;
                enable_d[i] = set_enable;
            end
        end
    end

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the slot array is reset as well; a stale time must never ring after power-up.
            for (int i = 0; i < NUM_ALARMS; i++) begin
                time_q[i] <= '0;
            end
            enable_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop sees pre-edge values.
            time_q   <= time_d;
            enable_q <= enable_d;
        end
    end

    // Matches use the registered contents, so a write on a tick cycle compares old data.
    always_comb begin
        slot_match = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            slot_match[i] = enable_q[i] && (time_q[i] == now);
        end
    end

    assign slot_enabled = enable_q;

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: picks the ringing source on each one-second
// tick and runs the IDLE / RING / SNOOZE sequence for the sample player.
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS     = 4,
    parameter int RING_SECONDS   = 7,
    parameter int SNOOZE_SECONDS = 300,
    parameter int CHIME_EN       = 1
) (
    input  logic                  CLK_50,
    input  logic                  RST_N,
    input  logic                  one_second_tick,
    input  logic [TIME_W-1:0]     hour,
    input  logic [TIME_W-1:0]     minute,
    input  logic [TIME_W-1:0]     second,
    input  logic                  set_valid,
    input  logic [2:0]            set_idx,
    input  logic [TIME_W-1:0]     set_hour,
    input  logic [TIME_W-1:0]     set_minute,
    input  logic [TIME_W-1:0]     set_second,
    input  logic                  set_enable,
    input  logic                  stop,
    input  logic                  snooze,
    output logic                  ringing,
    output logic [3:0]            ring_src,
    output logic [7:0]            ring_count,
    output logic [NUM_ALARMS-1:0] slot_enabled
);

    localparam logic [7:0]  RING_MAX    = 8'(RING_SECONDS);
    localparam logic [11:0] SNOOZE_INIT = 12'(SNOOZE_SECONDS);

    state_t      state_q,      state_d;
    logic [3:0]  ring_src_q,   ring_src_d;
    logic [7:0]  ring_count_q, ring_count_d;
    logic [11:0] snooze_cnt_q, snooze_cnt_d;

    hms_t                  now;
    hms_t                  set_time;
    logic [NUM_ALARMS-1:0] slot_match;
    logic                  chime_hit;
    logic                  hit;
    logic [3:0]            winner;

    assign now      = '{hour: hour, minute: minute, second: second};
    assign set_time = '{hour: set_hour, minute: set_minute, second: set_second};

    alarm_slot_bank #(
        .NUM_ALARMS (NUM_ALARMS)
    ) u_slot_bank (
        .CLK_50       (CLK_50),
        .RST_N        (RST_N),
        .set_valid    (set_valid),
        .set_idx      (set_idx),
        .set_time     (set_time),
        .set_enable   (set_enable),
        .now          (now),
        .slot_match   (slot_match),
        .slot_enabled (slot_enabled)
    );

    // Scanning downward lets the lowest matching slot overwrite the chime default.
    always_comb begin
        winner = CHIME_SRC;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_match[i]) begin
                winner = 4'(i);
            end
        end
        chime_hit = (CHIME_EN != 0) && (minute == 6'd59) && (second == 6'd59);
        hit       = one_second_tick && ((|slot_match) || chime_hit);
    end

    // Within each state: stop beats snooze beats tick/match.
    always_comb begin
        state_d      = state_q;
        ring_src_d   = ring_src_q;
        ring_count_d = ring_count_q;
        snooze_cnt_d = snooze_cnt_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d      = RING;
                    ring_count_d = 8'd1;
                    ring_src_d   = winner;
                end
            end
            RING: begin
                if (stop) begin
                    state_d      = IDLE;
                    ring_count_d = '0;
                end else if (snooze) begin
                    state_d      = SNOOZE;
                    ring_count_d = '0;
                    snooze_cnt_d = SNOOZE_INIT;
                end else if (hit) begin
                    ring_count_d = 8'd1;
                    ring_src_d   = winner;
                end else if (one_second_tick) begin
                    if (ring_count_q >= RING_MAX) begin
                        state_d      = IDLE;
                        ring_count_d = '0;
                    end else begin
                        ring_count_d = ring_count_q + 8'd1;
                    end
                end
            end
            SNOOZE: begin
                if (stop) begin
                    state_d      = IDLE;
                    snooze_cnt_d = '0;
                end else if (hit) begin
                    state_d      = RING;
                    ring_count_d = 8'd1;
                    ring_src_d   = winner;
                    snooze_cnt_d = '0;
                end else if (one_second_tick) begin
                    if (snooze_cnt_q <= 12'd1) begin
                        state_d      = RING;
                        ring_count_d = 8'd1;
                        snooze_cnt_d = '0;
                    end else begin
                        snooze_cnt_d = snooze_cnt_q - 12'd1;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                ring_count_d = '0;
                snooze_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            ring_src_q   <= '0;
            ring_count_q <= '0;
            snooze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            ring_src_q   <= ring_src_d;
            ring_count_q <= ring_count_d;
            snooze_cnt_q <= snooze_cnt_d;
        end
    end

    assign ringing    = (state_q == RING);
    assign ring_src   = ring_src_q;
    assign ring_count = ring_count_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: a vector table for single-cycle
// behaviour plus hand-written snooze, write-ordering and reset sequences.
module tb_alarm_scheduler;

    logic       CLK_50 = 1'b0;
    logic       RST_N  = 1'b1;
    logic       one_second_tick = 1'b0;
    logic [5:0] hour = '0, minute = '0, second = '0;
    logic       set_valid = 1'b0;
    logic [2:0] set_idx = '0;
    logic [5:0] set_hour = '0, set_minute = '0, set_second = '0;
    logic       set_enable = 1'b0;
    logic       stop = 1'b0;
    logic       snooze = 1'b0;

    logic       ringing,    nc_ringing;
    logic [3:0] ring_src,   nc_ring_src;
    logic [7:0] ring_count, nc_ring_count;
    logic [3:0] slot_enabled, nc_slot_enabled;

    int checks   = 0;
    int failures = 0;

    alarm_scheduler #(
        .NUM_ALARMS(4), .RING_SECONDS(7), .SNOOZE_SECONDS(5), .CHIME_EN(1)
    ) dut (
        .CLK_50(CLK_50), .RST_N(RST_N), .one_second_tick(one_second_tick),
        .hour(hour), .minute(minute), .second(second),
        .set_valid(set_valid), .set_idx(set_idx), .set_hour(set_hour),
        .set_minute(set_minute), .set_second(set_second), .set_enable(set_enable),
        .stop(stop), .snooze(snooze), .ringing(ringing), .ring_src(ring_src),
        .ring_count(ring_count), .slot_enabled(slot_enabled)
    );

    alarm_scheduler #(
        .NUM_ALARMS(4), .RING_SECONDS(7), .SNOOZE_SECONDS(5), .CHIME_EN(0)
    ) dut_nochime (
        .CLK_50(CLK_50), .RST_N(RST_N), .one_second_tick(one_second_tick),
        .hour(hour), .minute(minute), .second(second),
        .set_valid(set_valid), .set_idx(set_idx), .set_hour(set_hour),
        .set_minute(set_minute), .set_second(set_second), .set_enable(set_enable),
        .stop(stop), .snooze(snooze), .ringing(nc_ringing), .ring_src(nc_ring_src),
        .ring_count(nc_ring_count), .slot_enabled(nc_slot_enabled)
    );

    always #5 CLK_50 = ~CLK_50;

    typedef struct {
        int tk, h, m, s;
        int sv, si, sh, sm, ss, se;
        int stp, snz;
        int e_ring, e_src, e_cnt, e_en;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic do_tick(input int h, input int m, input int s);
        hour = 6'(h);
        minute = 6'(m);
        second = 6'(s);
        one_second_tick = 1'b1;
        cycle();
        one_second_tick = 1'b0;
    endtask

    task automatic set_slot(input int idx, input int h, input int m, input int s, input int en);
        set_valid  = 1'b1;
        set_idx    = 3'(idx);
        set_hour   = 6'(h);
        set_minute = 6'(m);
        set_second = 6'(s);
        set_enable = 1'(en);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        cycle();
        snooze = 1'b0;
    endtask

    task automatic expect_out(input string name, input int ring, input int src, input int cnt);
        check({name, "_ringing"}, 32'(ringing), 32'(ring));
        check({name, "_src"}, 32'(ring_src), 32'(src));
        check({name, "_count"}, 32'(ring_count), 32'(cnt));
    endtask

    task automatic expect_reset(input string name);
        expect_out(name, 0, 0, 0);
        check({name, "_slot_en"}, 32'(slot_enabled), 0);
    endtask

    initial begin
        int sec_in_hour;
        int exp_ring;

        #2 RST_N = 1'b0;
        repeat (3) cycle();
        expect_reset("reset");
        check("reset_nochime_ringing", 32'(nc_ringing), 0);
        RST_N = 1'b1;
        cycle();

        // Two hours of ticks with no writes: only the chime may ring.
        for (int t = 0; t < 7200; t++) begin
            do_tick(t / 3600, (t / 60) % 60, t % 60);
            sec_in_hour = t % 3600;
            exp_ring = ((sec_in_hour == 3599) || (sec_in_hour <= 5 && t >= 3600)) ? 1 : 0;
            check($sformatf("chime_ringing_t%0d", t), 32'(ringing), 32'(exp_ring));
            if (sec_in_hour == 3599) begin
                check($sformatf("chime_src_t%0d", t), 32'(ring_src), 15);
            end
            check($sformatf("nochime_ringing_t%0d", t), 32'(nc_ringing), 0);
            cycle();
        end

        RST_N = 1'b0;
        #1;
        expect_reset("reset2");
        cycle();
        RST_N = 1'b1;
        cycle();

        //                tk h  m  s   sv si sh  sm  ss se  stp snz ring src cnt en
        vecs.push_back(vec_t'{0, 0, 0, 0,  1, 2, 7, 30, 0, 1,  0, 0,  0, 0, 0, 4});
        vecs.push_back(vec_t'{1, 7, 29, 59, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 4});
        vecs.push_back(vec_t'{1, 7, 30, 0,  0, 0, 0, 0, 0, 0,  0, 0,  1, 2, 1, 4});
        vecs.push_back(vec_t'{1, 7, 30, 1,  0, 0, 0, 0, 0, 0,  0, 0,  1, 2, 2, 4});
        vecs.push_back(vec_t'{1, 7, 30, 2,  0, 0, 0, 0, 0, 0,  0, 0,  1, 2, 3, 4});
        vecs.push_back(vec_t'{1, 7, 30, 3,  0, 0, 0, 0, 0, 0,  0, 0,  1, 2, 4, 4});
        vecs.push_back(vec_t'{1, 7, 30, 4,  0, 0, 0, 0, 0, 0,  0, 0,  1, 2, 5, 4});
        vecs.push_back(vec_t'{1, 7, 30, 5,  0, 0, 0, 0, 0, 0,  0, 0,  1, 2, 6, 4});
        vecs.push_back(vec_t'{1, 7, 30, 6,  0, 0, 0, 0, 0, 0,  0, 0,  1, 2, 7, 4});
        vecs.push_back(vec_t'{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0,  1, 2, 7, 4});
        vecs.push_back(vec_t'{1, 7, 30, 7,  0, 0, 0, 0, 0, 0,  0, 0,  0, 2, 0, 4});
        vecs.push_back(vec_t'{0, 0, 0, 0,  1, 1, 10, 59, 59, 1, 0, 0, 0, 2, 0, 6});
        vecs.push_back(vec_t'{0, 0, 0, 0,  1, 3, 10, 59, 59, 1, 0, 0, 0, 2, 0, 14});
        vecs.push_back(vec_t'{1, 10, 59, 59, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 14});
        vecs.push_back(vec_t'{1, 11, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0,  1, 1, 2, 14});
        vecs.push_back(vec_t'{1, 7, 30, 0,  0, 0, 0, 0, 0, 0,  0, 0,  1, 2, 1, 14});
        vecs.push_back(vec_t'{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0,  0, 2, 0, 14});
        vecs.push_back(vec_t'{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0,  0, 2, 0, 14});
        vecs.push_back(vec_t'{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1,  0, 2, 0, 14});
        vecs.push_back(vec_t'{0, 0, 0, 0,  1, 2, 7, 30, 0, 0,  0, 0,  0, 2, 0, 10});
        vecs.push_back(vec_t'{1, 7, 30, 0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 2, 0, 10});
        vecs.push_back(vec_t'{0, 0, 0, 0,  1, 4, 12, 0, 0, 1,  0, 0,  0, 2, 0, 10});
        vecs.push_back(vec_t'{0, 0, 0, 0,  1, 7, 12, 0, 0, 1,  0, 0,  0, 2, 0, 10});
        vecs.push_back(vec_t'{1, 12, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 2, 0, 10});
        vecs.push_back(vec_t'{1, 0, 59, 59, 0, 0, 0, 0, 0, 0,  0, 0,  1, 15, 1, 10});
        vecs.push_back(vec_t'{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0,  0, 15, 0, 10});

        foreach (vecs[i]) begin
            one_second_tick = 1'(vecs[i].tk);
            hour   = 6'(vecs[i].h);
            minute = 6'(vecs[i].m);
            second = 6'(vecs[i].s);
            set_valid  = 1'(vecs[i].sv);
            set_idx    = 3'(vecs[i].si);
            set_hour   = 6'(vecs[i].sh);
            set_minute = 6'(vecs[i].sm);
            set_second = 6'(vecs[i].ss);
            set_enable = 1'(vecs[i].se);
            stop   = 1'(vecs[i].stp);
            snooze = 1'(vecs[i].snz);
            cycle();
            one_second_tick = 1'b0;
            set_valid = 1'b0;
            stop = 1'b0;
            snooze = 1'b0;
            expect_out($sformatf("vec%0d", i), vecs[i].e_ring, vecs[i].e_src, vecs[i].e_cnt);
            check($sformatf("vec%0d_slot_en", i), 32'(slot_enabled), 32'(vecs[i].e_en));
        end

        // Snooze at ring_count=3: silent for 5 ticks, then re-ring from slot 0.
        set_slot(0, 6, 0, 0, 1);
        cycle();
        set_valid = 1'b0;
        check("snz_slot_en", 32'(slot_enabled), 11);
        do_tick(6, 0, 0);
        do_tick(6, 0, 1);
        do_tick(6, 0, 2);
        expect_out("snz_before", 1, 0, 3);
        pulse_snooze();
        expect_out("snz_enter", 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            do_tick(6, 10, k);
            check($sformatf("snz_tick%0d_ringing", k), 32'(ringing), (k == 5) ? 1 : 0);
            if (k == 2) begin
                pulse_snooze();
            end
        end
        expect_out("snz_rering", 1, 0, 1);
        do_tick(6, 10, 6);
        expect_out("snz_rering2", 1, 0, 2);

        // Stop during SNOOZE cancels the pending re-ring.
        pulse_snooze();
        pulse_stop();
        expect_out("snz_stop", 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            do_tick(6, 11, k);
            check($sformatf("snz_stop_tick%0d_ringing", k), 32'(ringing), 0);
        end

        // Stop and snooze on the same cycle: stop wins.
        do_tick(6, 0, 0);
        stop = 1'b1;
        snooze = 1'b1;
        cycle();
        stop = 1'b0;
        snooze = 1'b0;
        expect_out("stop_snz_same", 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            do_tick(6, 12, k);
            check($sformatf("stop_snz_tick%0d_ringing", k), 32'(ringing), 0);
        end

        // A match while snoozing rings immediately with the new source.
        do_tick(6, 0, 0);
        pulse_snooze();
        do_tick(10, 59, 59);
        expect_out("snz_match", 1, 1, 1);
        pulse_stop();

        // A write on a tick cycle is compared using the slot's old contents.
        set_slot(0, 8, 0, 0, 1);
        cycle();
        set_slot(0, 9, 0, 0, 1);
        do_tick(8, 0, 0);
        set_valid = 1'b0;
        expect_out("old_contents_ring", 1, 0, 1);
        pulse_stop();
        do_tick(8, 0, 0);
        check("new_contents_ringing", 32'(ringing), 0);

        set_slot(0, 8, 0, 0, 0);
        cycle();
        set_slot(0, 8, 0, 0, 1);
        do_tick(8, 0, 0);
        set_valid = 1'b0;
        check("old_disabled_ringing", 32'(ringing), 0);
        check("old_disabled_slot_en", 32'(slot_enabled), 11);
        do_tick(8, 0, 0);
        do_tick(8, 0, 1);
        do_tick(8, 0, 2);
        do_tick(8, 0, 3);
        expect_out("pre_reset", 1, 0, 4);

        // Asynchronous reset mid-ring, checked before the next clock edge.
        #2 RST_N = 1'b0;
        #1;
        expect_reset("async_reset");
        cycle();
        cycle();
        RST_N = 1'b1;
        cycle();
        do_tick(8, 0, 0);
        check("post_reset_old_time_ringing", 32'(ringing), 0);
        do_tick(0, 0, 0);
        check("post_reset_zero_time_ringing", 32'(ringing), 0);
        set_slot(3, 0, 0, 5, 1);
        cycle();
        set_valid = 1'b0;
        do_tick(0, 0, 5);
        expect_out("post_reset_new_match", 1, 3, 1);
        do_tick(10, 59, 59);
        expect_out("post_reset_chime_restart", 1, 15, 1);
        pulse_stop();
        expect_out("final_stop", 0, 15, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
